// File: rtl/commit_unit_multi_pkg.sv
// Shared constants, instruction type codes and FSM encoding for the multi-lane commit stage.
package commit_unit_multi_pkg;

  localparam logic [4:0]  ZERO_REGFILE  = 5'd0;
  localparam logic [3:0]  ZERO_ROB      = 4'd0;
  localparam logic [31:0] ZERO_DATA     = 32'd0;
  localparam logic [31:0] ZERO_ADDR     = 32'd0;

  localparam logic [2:0]  ALU_TYPE      = 3'd0;
  localparam logic [2:0]  STORE_TYPE    = 3'd1;
  localparam logic [2:0]  JUMP_TYPE     = 3'd2;

  localparam logic        FLUSH_ENABLE  = 1'b1;
  localparam logic        FLUSH_DISABLE = 1'b0;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_WAIT_STORE = 2'd1,
    ST_FLUSH      = 2'd2
  } commit_state_t;

endpackage

// File: rtl/commit_unit_multi_lane_scan.sv
// Combinational priority scan over the ROB head lanes: finds the retirable prefix,
// a taken jump inside it, a store sitting at the head, and the deduplicated write mask.
module commit_unit_multi_lane_scan
  import commit_unit_multi_pkg::*;
#(
  parameter int COMMIT_WIDTH = 2,
  parameter int REG_W        = 5,
  parameter int TYPE_W       = 3,
  parameter int CNT_W        = $clog2(COMMIT_WIDTH + 1),
  parameter int IDX_W        = (COMMIT_WIDTH > 1) ? $clog2(COMMIT_WIDTH) : 1
) (
  input  logic [COMMIT_WIDTH-1:0]        head_valid,
  input  logic [COMMIT_WIDTH*REG_W-1:0]  dest,
  input  logic [COMMIT_WIDTH*TYPE_W-1:0] itype,
  input  logic [COMMIT_WIDTH-1:0]        jump,
  output logic [CNT_W-1:0]               pop_cnt,
  output logic [COMMIT_WIDTH-1:0]        write_mask,
  output logic                           store_head,
  output logic                           jump_hit,
  output logic [IDX_W-1:0]               jump_idx
);

  logic [COMMIT_WIDTH-1:0] retire;
  logic                    stop;

  // Walk lanes oldest-first; a store beyond lane 0 waits to become the head itself.
  always_comb begin
    retire     = '0;
    store_head = 1'b0;
    jump_hit   = 1'b0;
    jump_idx   = '0;
    stop       = 1'b0;
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      if (stop) begin
        retire[i] = 1'b0;
      end else if (!head_valid[i]) begin
        stop = 1'b1;
      end else if (itype[i*TYPE_W +: TYPE_W] == TYPE_W'(STORE_TYPE)) begin
        stop = 1'b1;
        if (i == 0) begin
          store_head = 1'b1;
        end else begin
          store_head = store_head;
        end
      end else begin
        retire[i] = 1'b1;
        if (jump[i] && (itype[i*TYPE_W +: TYPE_W] == TYPE_W'(JUMP_TYPE))) begin
          jump_hit = 1'b1;
          jump_idx = IDX_W'(i);
          stop     = 1'b1;
        end else begin
          jump_hit = jump_hit;
        end
      end
    end
  end

  // Count the prefix and drop writes to x0 or shadowed by a younger lane with the same dest.
  always_comb begin
    pop_cnt    = '0;
    write_mask = '0;
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      pop_cnt       = pop_cnt + CNT_W'(retire[i]);
      write_mask[i] = retire[i] && (dest[i*REG_W +: REG_W] != REG_W'(ZERO_REGFILE));
      for (int j = i + 1; j < COMMIT_WIDTH; j++) begin
        if (retire[j] && (dest[j*REG_W +: REG_W] == dest[i*REG_W +: REG_W])) begin
          write_mask[i] = 1'b0;
        end else begin
          write_mask[i] = write_mask[i];
        end
      end
    end
  end

endmodule

// File: rtl/commit_unit_multi.sv
// In-order multi-lane retirement stage: registered regfile writes, serialised stores
// through an LSB req/ack handshake, and a one-cycle flush/redirect on a taken jump.
module commit_unit_multi
  import commit_unit_multi_pkg::*;
#(
  parameter int COMMIT_WIDTH = 2,
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 32,
  parameter int REG_W        = 5,
  parameter int ROB_W        = 4,
  parameter int TYPE_W       = 3,
  parameter int CNT_W        = $clog2(COMMIT_WIDTH + 1)
) (
  input  logic                           clk_in,
  input  logic                           rst_in,
  input  logic [COMMIT_WIDTH-1:0]        head_valid_from_rob,
  input  logic [COMMIT_WIDTH*REG_W-1:0]  regfile_pos_from_rob,
  input  logic [COMMIT_WIDTH*ROB_W-1:0]  rob_pos_from_rob,
  input  logic [COMMIT_WIDTH*DATA_W-1:0] data_from_rob,
  input  logic [COMMIT_WIDTH*ADDR_W-1:0] jump_addr_from_rob,
  input  logic [COMMIT_WIDTH*TYPE_W-1:0] type_from_rob,
  input  logic [COMMIT_WIDTH-1:0]        jump_from_rob,
  input  logic                           store_ack_from_lsb,
  output logic [CNT_W-1:0]               pop_cnt_to_rob,
  output logic [COMMIT_WIDTH-1:0]        write_to_regfile,
  output logic [COMMIT_WIDTH*REG_W-1:0]  addr_to_regfile,
  output logic [COMMIT_WIDTH*ROB_W-1:0]  rob_pos_to_regfile,
  output logic [COMMIT_WIDTH*DATA_W-1:0] data_to_regfile,
  output logic                           store_req_to_lsb,
  output logic [ROB_W-1:0]               store_rob_pos_to_lsb,
  output logic                           flush_from_commit,
  output logic                           jump_from_commit,
  output logic [ADDR_W-1:0]              jump_addr_from_commit
);

  localparam int IDX_W = (COMMIT_WIDTH > 1) ? $clog2(COMMIT_WIDTH) : 1;

  commit_state_t             state;
  logic [CNT_W-1:0]          scan_pop;
  logic [COMMIT_WIDTH-1:0]   write_mask;
  logic                      store_head;
  logic                      jump_hit;
  logic [IDX_W-1:0]          jump_idx;
  logic [COMMIT_WIDTH*REG_W-1:0]  addr_next;
  logic [COMMIT_WIDTH*ROB_W-1:0]  tag_next;
  logic [COMMIT_WIDTH*DATA_W-1:0] data_next;

  commit_unit_multi_lane_scan #(
    .COMMIT_WIDTH (COMMIT_WIDTH),
    .REG_W        (REG_W),
    .TYPE_W       (TYPE_W),
    .CNT_W        (CNT_W),
    .IDX_W        (IDX_W)
  ) u_scan (
    .head_valid (head_valid_from_rob),
    .dest       (regfile_pos_from_rob),
    .itype      (type_from_rob),
    .jump       (jump_from_rob),
    .pop_cnt    (scan_pop),
    .write_mask (write_mask),
    .store_head (store_head),
    .jump_hit   (jump_hit),
    .jump_idx   (jump_idx)
  );

  // Non-writing lanes present all-zero address, tag and data to the regfile.
  always_comb begin
    addr_next = '0;
    tag_next  = '0;
    data_next = '0;
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      if (write_mask[i]) begin
        addr_next[i*REG_W +: REG_W]   = regfile_pos_from_rob[i*REG_W +: REG_W];
        tag_next[i*ROB_W +: ROB_W]    = rob_pos_from_rob[i*ROB_W +: ROB_W];
        data_next[i*DATA_W +: DATA_W] = data_from_rob[i*DATA_W +: DATA_W];
      end else begin
        addr_next[i*REG_W +: REG_W]   = REG_W'(ZERO_REGFILE);
        tag_next[i*ROB_W +: ROB_W]    = ROB_W'(ZERO_ROB);
        data_next[i*DATA_W +: DATA_W] = DATA_W'(ZERO_DATA);
      end
    end
  end

  // Combinational pop: the ROB removes these entries at the coming edge.
  always_comb begin
    pop_cnt_to_rob = '0;
    if (rst_in) begin
      pop_cnt_to_rob = '0;
    end else begin
      case (state)
        ST_RUN:        pop_cnt_to_rob = scan_pop;
        ST_WAIT_STORE: pop_cnt_to_rob = store_ack_from_lsb ? CNT_W'(1) : CNT_W'(0);
        ST_FLUSH:      pop_cnt_to_rob = '0;
        default:       pop_cnt_to_rob = '0;
      endcase
    end
  end

  // Commit FSM with registered regfile, store and redirect outputs.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state                 <= ST_RUN;
      write_to_regfile      <= '0;
      addr_to_regfile       <= '0;
      rob_pos_to_regfile    <= '0;
      data_to_regfile       <= '0;
      store_req_to_lsb      <= 1'b0;
      store_rob_pos_to_lsb  <= ROB_W'(ZERO_ROB);
      flush_from_commit     <= FLUSH_DISABLE;
      jump_addr_from_commit <= ADDR_W'(ZERO_ADDR);
    end else begin
      write_to_regfile      <= '0;
      addr_to_regfile       <= '0;
      rob_pos_to_regfile    <= '0;
      data_to_regfile       <= '0;
      flush_from_commit     <= FLUSH_DISABLE;
      jump_addr_from_commit <= ADDR_W'(ZERO_ADDR);
      case (state)
        ST_RUN: begin
          if (store_head) begin
            store_req_to_lsb     <= 1'b1;
            store_rob_pos_to_lsb <= rob_pos_from_rob[ROB_W-1:0];
            state                <= ST_WAIT_STORE;
          end else begin
            write_to_regfile   <= write_mask;
            addr_to_regfile    <= addr_next;
            rob_pos_to_regfile <= tag_next;
            data_to_regfile    <= data_next;
            if (jump_hit) begin
              flush_from_commit     <= FLUSH_ENABLE;
              jump_addr_from_commit <= jump_addr_from_rob[jump_idx*ADDR_W +: ADDR_W];
              state                 <= ST_FLUSH;
            end else begin
              state <= ST_RUN;
            end
          end
        end
        ST_WAIT_STORE: begin
          if (store_ack_from_lsb) begin
            store_req_to_lsb     <= 1'b0;
            store_rob_pos_to_lsb <= ROB_W'(ZERO_ROB);
            state                <= ST_RUN;
          end else begin
            state <= ST_WAIT_STORE;
          end
        end
        ST_FLUSH: state <= ST_RUN;
        default:  state <= ST_RUN;
      endcase
    end
  end

  assign jump_from_commit = flush_from_commit;

endmodule

// File: tb/tb_commit_unit_multi.sv
// Scoreboard bench for commit_unit_multi at COMMIT_WIDTH=2: pop is checked in-cycle,
// expected registered outputs are queued at drive time and compared after the edge.
module tb_commit_unit_multi;
  import commit_unit_multi_pkg::*;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic [1:0]  hv = '0;
  logic [9:0]  rp = '0;
  logic [7:0]  tg = '0;
  logic [63:0] dt = '0;
  logic [63:0] ja = '0;
  logic [5:0]  ty = '0;
  logic [1:0]  jf = '0;
  logic        ack = 1'b0;

  logic [1:0]  pop_cnt;
  logic [1:0]  wr;
  logic [9:0]  waddr;
  logic [7:0]  wtag;
  logic [63:0] wdata;
  logic        sreq;
  logic [3:0]  spos;
  logic        flush;
  logic        jmp;
  logic [31:0] jaddr;

  typedef struct {
    logic [1:0]  wr;
    logic [9:0]  addr;
    logic [7:0]  tag;
    logic [63:0] data;
    logic        req;
    logic [3:0]  spos;
    logic        flush;
    logic [31:0] jaddr;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  commit_unit_multi #(.COMMIT_WIDTH(2)) dut (
    .clk_in                (clk_in),
    .rst_in                (rst_in),
    .head_valid_from_rob   (hv),
    .regfile_pos_from_rob  (rp),
    .rob_pos_from_rob      (tg),
    .data_from_rob         (dt),
    .jump_addr_from_rob    (ja),
    .type_from_rob         (ty),
    .jump_from_rob         (jf),
    .store_ack_from_lsb    (ack),
    .pop_cnt_to_rob        (pop_cnt),
    .write_to_regfile      (wr),
    .addr_to_regfile       (waddr),
    .rob_pos_to_regfile    (wtag),
    .data_to_regfile       (wdata),
    .store_req_to_lsb      (sreq),
    .store_rob_pos_to_lsb  (spos),
    .flush_from_commit     (flush),
    .jump_from_commit      (jmp),
    .jump_addr_from_commit (jaddr)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic set_lane(input int i, input logic v, input logic [4:0] d, input logic [3:0] t,
                          input logic [31:0] data, input logic [2:0] typ, input logic j,
                          input logic [31:0] tgt);
    hv[i]          = v;
    rp[i*5 +: 5]   = d;
    tg[i*4 +: 4]   = t;
    dt[i*32 +: 32] = data;
    ty[i*3 +: 3]   = typ;
    jf[i]          = j;
    ja[i*32 +: 32] = tgt;
  endtask

  function automatic exp_t mk(input logic [1:0] w, input logic [9:0] a, input logic [7:0] t,
                              input logic [63:0] d, input logic r, input logic [3:0] sp,
                              input logic f, input logic [31:0] jd);
    exp_t e;
    e.wr = w; e.addr = a; e.tag = t; e.data = d;
    e.req = r; e.spos = sp; e.flush = f; e.jaddr = jd;
    return e;
  endfunction

  function automatic exp_t zero_exp();
    return mk(2'b00, 10'd0, 8'd0, 64'd0, 1'b0, 4'd0, 1'b0, 32'd0);
  endfunction

  task automatic compare_outputs(input string tag, input exp_t e);
    check({tag, ".wr"},    64'(wr),    64'(e.wr));
    check({tag, ".addr"},  64'(waddr), 64'(e.addr));
    check({tag, ".tag"},   64'(wtag),  64'(e.tag));
    check({tag, ".data"},  wdata,      e.data);
    check({tag, ".sreq"},  64'(sreq),  64'(e.req));
    check({tag, ".spos"},  64'(spos),  64'(e.spos));
    check({tag, ".flush"}, 64'(flush), 64'(e.flush));
    check({tag, ".jump"},  64'(jmp),   64'(e.flush));
    check({tag, ".jaddr"}, 64'(jaddr), 64'(e.jaddr));
  endtask

  // One cycle: inputs already driven; check pop mid-cycle, queue expectation, compare after edge.
  task automatic step(input string tag, input logic [1:0] exp_pop, input exp_t e);
    exp_t got_e;
    @(negedge clk_in);
    check({tag, ".pop"}, 64'(pop_cnt), 64'(exp_pop));
    sb_q.push_back(e);
    @(posedge clk_in);
    #1;
    if (sb_q.size() == 0) begin
      check({tag, ".sb_empty"}, 64'd1, 64'd0);
    end else begin
      got_e = sb_q.pop_front();
      compare_outputs(tag, got_e);
    end
  endtask

  initial begin
    #2;
    check("rst.pop", 64'(pop_cnt), 64'd0);
    compare_outputs("rst", zero_exp());
    @(negedge clk_in);
    rst_in = 1'b0;
    @(posedge clk_in);
    #1;

    // Two ALU lanes x3/x5
    set_lane(0, 1'b1, 5'd3, 4'd1, 32'h11, ALU_TYPE, 1'b0, 32'd0);
    set_lane(1, 1'b1, 5'd5, 4'd2, 32'h22, ALU_TYPE, 1'b0, 32'd0);
    step("alu2", 2'd2, mk(2'b11, {5'd5, 5'd3}, {4'd2, 4'd1}, {32'h22, 32'h11}, 1'b0, 4'd0, 1'b0, 32'd0));

    // Lane 0 to x0 does not write
    set_lane(0, 1'b1, 5'd0, 4'd3, 32'h33, ALU_TYPE, 1'b0, 32'd0);
    set_lane(1, 1'b1, 5'd7, 4'd4, 32'h44, ALU_TYPE, 1'b0, 32'd0);
    step("x0", 2'd2, mk(2'b10, {5'd7, 5'd0}, {4'd4, 4'd0}, {32'h44, 32'h0}, 1'b0, 4'd0, 1'b0, 32'd0));

    // Same destination: youngest wins
    set_lane(0, 1'b1, 5'd4, 4'd6, 32'hA6, ALU_TYPE, 1'b0, 32'd0);
    set_lane(1, 1'b1, 5'd4, 4'd7, 32'hA7, ALU_TYPE, 1'b0, 32'd0);
    step("samedst", 2'd2, mk(2'b10, {5'd4, 5'd0}, {4'd7, 4'd0}, {32'hA7, 32'h0}, 1'b0, 4'd0, 1'b0, 32'd0));

    // Invalid head retires nothing, and a valid lane 1 behind it is not skipped
    set_lane(0, 1'b0, 5'd2, 4'd1, 32'h1, ALU_TYPE, 1'b0, 32'd0);
    set_lane(1, 1'b1, 5'd3, 4'd2, 32'h2, ALU_TYPE, 1'b0, 32'd0);
    step("nohead", 2'd0, zero_exp());

    // Jump flag on a non-jump type is not a redirect
    set_lane(0, 1'b1, 5'd6, 4'd2, 32'h66, ALU_TYPE, 1'b1, 32'h500);
    set_lane(1, 1'b1, 5'd8, 4'd3, 32'h88, ALU_TYPE, 1'b0, 32'd0);
    step("fakejmp", 2'd2, mk(2'b11, {5'd8, 5'd6}, {4'd3, 4'd2}, {32'h88, 32'h66}, 1'b0, 4'd0, 1'b0, 32'd0));

    // Ack while in RUN is ignored
    set_lane(0, 1'b0, 5'd0, 4'd0, 32'h0, ALU_TYPE, 1'b0, 32'd0);
    set_lane(1, 1'b0, 5'd0, 4'd0, 32'h0, ALU_TYPE, 1'b0, 32'd0);
    ack = 1'b1;
    step("ackrun", 2'd0, zero_exp());
    ack = 1'b0;

    // ALU then store in lane 1: only lane 0 retires
    set_lane(0, 1'b1, 5'd9, 4'd8, 32'h99, ALU_TYPE, 1'b0, 32'd0);
    set_lane(1, 1'b1, 5'd0, 4'd9, 32'h0, STORE_TYPE, 1'b0, 32'd0);
    step("alust", 2'd1, mk(2'b01, {5'd0, 5'd9}, {4'd0, 4'd8}, {32'h0, 32'h99}, 1'b0, 4'd0, 1'b0, 32'd0));

    // Store now at head
    set_lane(0, 1'b1, 5'd0, 4'd9, 32'h0, STORE_TYPE, 1'b0, 32'd0);
    set_lane(1, 1'b1, 5'd10, 4'd10, 32'hAA, ALU_TYPE, 1'b0, 32'd0);
    step("sthead", 2'd0, mk(2'b00, 10'd0, 8'd0, 64'd0, 1'b1, 4'd9, 1'b0, 32'd0));
    for (int k = 0; k < 3; k++) begin
      step($sformatf("stwait%0d", k), 2'd0, mk(2'b00, 10'd0, 8'd0, 64'd0, 1'b1, 4'd9, 1'b0, 32'd0));
    end
    ack = 1'b1;
    step("stack", 2'd1, zero_exp());
    ack = 1'b0;
    set_lane(0, 1'b1, 5'd10, 4'd10, 32'hAA, ALU_TYPE, 1'b0, 32'd0);
    set_lane(1, 1'b0, 5'd0, 4'd0, 32'h0, ALU_TYPE, 1'b0, 32'd0);
    step("poststore", 2'd1, mk(2'b01, {5'd0, 5'd10}, {4'd0, 4'd10}, {32'h0, 32'hAA}, 1'b0, 4'd0, 1'b0, 32'd0));

    // Taken jump in lane 0 stops the group
    set_lane(0, 1'b1, 5'd1, 4'd3, 32'h44, JUMP_TYPE, 1'b1, 32'h1000);
    set_lane(1, 1'b1, 5'd2, 4'd4, 32'h55, ALU_TYPE, 1'b0, 32'd0);
    step("jmp0", 2'd1, mk(2'b01, {5'd0, 5'd1}, {4'd0, 4'd3}, {32'h0, 32'h44}, 1'b0, 4'd0, 1'b1, 32'h1000));
    step("flush0", 2'd0, zero_exp());

    // Taken jump in lane 1 with dest x0
    set_lane(0, 1'b1, 5'd2, 4'd4, 32'h55, ALU_TYPE, 1'b0, 32'd0);
    set_lane(1, 1'b1, 5'd0, 4'd5, 32'h0, JUMP_TYPE, 1'b1, 32'h2000);
    step("jmp1", 2'd2, mk(2'b01, {5'd0, 5'd2}, {4'd0, 4'd4}, {32'h0, 32'h55}, 1'b0, 4'd0, 1'b1, 32'h2000));
    step("flush1", 2'd0, zero_exp());

    // Reset in the middle of a store wait
    set_lane(0, 1'b1, 5'd0, 4'd12, 32'h0, STORE_TYPE, 1'b0, 32'd0);
    set_lane(1, 1'b0, 5'd0, 4'd0, 32'h0, ALU_TYPE, 1'b0, 32'd0);
    step("st2", 2'd0, mk(2'b00, 10'd0, 8'd0, 64'd0, 1'b1, 4'd12, 1'b0, 32'd0));
    rst_in = 1'b1;
    #1;
    check("midrst.pop", 64'(pop_cnt), 64'd0);
    compare_outputs("midrst", zero_exp());
    @(negedge clk_in);
    rst_in = 1'b0;
    set_lane(0, 1'b1, 5'd3, 4'd1, 32'h11, ALU_TYPE, 1'b0, 32'd0);
    set_lane(1, 1'b1, 5'd5, 4'd2, 32'h22, ALU_TYPE, 1'b0, 32'd0);
    step("afterrst", 2'd2, mk(2'b11, {5'd5, 5'd3}, {4'd2, 4'd1}, {32'h22, 32'h11}, 1'b0, 4'd0, 1'b0, 32'd0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
